// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: state encodings, gate truth tables and sizing helper for the gate BIST engine
package gate_bist_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  function automatic int cnt_width(input int settle);
    return settle > 0 ? $clog2(settle + 1) : 1;
  endfunction
endpackage

// File: rtl/gate_bist_controller_settle.sv
// bist_settle_counter: loadable down-counter with zero flag, holds at zero
module bist_settle_counter #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/gate_bist_controller.sv
// gate_bist_controller: walks a 2-input gate through all four vectors and checks it against a truth table
module gate_bist_controller
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NAND,
  parameter int         SETTLE_CYCLES = 1,
  parameter int         ERR_W         = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  output logic             in1,
  output logic             in2,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] num_errors,
  output logic [3:0]       fail_vec
);
  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);
  state_t state;
  logic [1:0] vec_idx;
  logic zero, load, dec, last, mismatch;
  logic [CW-1:0] cnt;
  assign last = vec_idx == 2'd3;
  // 4-state compare so an X/Z gate output in simulation counts as a mismatch
  assign mismatch = dut_out !== TRUTH_TABLE[vec_idx];
  assign load = (state != ST_RUN) ? start : (zero && !last);
  assign dec = state == ST_RUN;
  assign {in1, in2} = vec_idx;
  assign pass = done && (num_errors == '0);
  bist_settle_counter #(.W(CW)) u_settle (
    .clock    (clock),
    .resetn   (resetn),
    .load     (load),
    .dec      (dec),
    .load_val (RELOAD),
    .cnt      (cnt),
    .zero     (zero)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state      <= ST_IDLE;
      vec_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      num_errors <= '0;
      fail_vec   <= '0;
    end else if (state != ST_RUN) begin
      if (start) begin
        state      <= ST_RUN;
        vec_idx    <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
        num_errors <= '0;
        fail_vec   <= '0;
      end
    end else if (zero) begin
      if (mismatch) begin
        fail_vec[vec_idx] <= 1'b1;
        if (num_errors != '1) num_errors <= num_errors + 1'b1;
      end
      if (last) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else vec_idx <= vec_idx + 2'd1;
    end
endmodule
